// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: synchroniser, per-input glitch filter, step/dir decode and wrapping position.
// Optional index (Z) input, which zeroes the position, is enabled by defining QDEC_INDEX_EN.
module quadrature_decoder #(
    parameter int BITS          = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_in,
    input  logic            b_in,
`ifdef QDEC_INDEX_EN
    input  logic            z_in,
`endif
    input  logic            clear,
    input  logic            error_clr,
    output logic            step,
    output logic            dir,
    output logic [BITS-1:0] position,
    output logic            error
`ifdef QDEC_INDEX_EN
    ,
    output logic            index_pulse
`endif
);

`ifdef QDEC_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam int PW = $clog2(SYNC_STAGES + 1);

    // Channel order: 0 = B, 1 = A, 2 = Z.
    logic [NCH-1:0]                  raw;
    logic [NCH-1:0]                  sync_out;
    logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NCH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [NCH-1:0]                  filt_q, filt_d, lvl_q, lvl_d, prev_q, prev_d;
    logic [PW-1:0]                   prime_cnt_q, prime_cnt_d;
    logic                            primed_q, primed_d;
    logic                            step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic [BITS-1:0]                 pos_q, pos_d;
    logic [3:0]                      tr;
    logic                            up, down, illegal, idx_rise;

`ifdef QDEC_INDEX_EN
    logic idx_q;
    assign raw      = {z_in, a_in, b_in};
    assign idx_rise = lvl_q[2] & ~prev_q[2];
`else
    assign raw      = {a_in, b_in};
    assign idx_rise = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end

    // Until the synchroniser has refilled after reset, the filtered and decode
    // levels follow it directly so the first real level never looks like motion.
    always_comb begin
        sync_d      = sync_q;
        cnt_d       = cnt_q;
        filt_d      = filt_q;
        lvl_d       = filt_q;
        prev_d      = lvl_q;
        prime_cnt_d = prime_cnt_q;
        primed_d    = primed_q;
        for (int i = 0; i < NCH; i++) sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (!primed_q) begin
            filt_d      = sync_out;
            lvl_d       = sync_out;
            prev_d      = sync_out;
            cnt_d       = '0;
            prime_cnt_d = prime_cnt_q + 1'b1;
            if (prime_cnt_q == PW'(SYNC_STAGES)) primed_d = 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync_out[i] != filt_q[i]) begin
                    if (cnt_q[i] == CW'(FILTER_CYCLES - 1)) begin
                        filt_d[i] = sync_out[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    // Decode {A,B} previous -> current; A leading B counts up.
    assign tr      = {prev_q[1:0], lvl_q[1:0]};
    assign illegal = (prev_q[1] ^ lvl_q[1]) & (prev_q[0] ^ lvl_q[0]);

    always_comb begin
        up   = 1'b0;
        down = 1'b0;
        case (tr)
            4'b0010, 4'b1011, 4'b1101, 4'b0100: up   = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: down = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        step_d = up | down;
        dir_d  = dir_q;
        pos_d  = pos_q;
        err_d  = err_q;
        if (up) begin
            dir_d = 1'b1;
            pos_d = pos_q + 1'b1;
        end else if (down) begin
            dir_d = 1'b0;
            pos_d = pos_q - 1'b1;
        end
        if (clear || idx_rise) pos_d = '0;
        if (error_clr) err_d = 1'b0;
        if (illegal)   err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            filt_q      <= '0;
            lvl_q       <= '0;
            prev_q      <= '0;
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            pos_q       <= '0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            lvl_q       <= lvl_d;
            prev_q      <= prev_d;
            prime_cnt_q <= prime_cnt_d;
            primed_q    <= primed_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            pos_q       <= pos_d;
        end
    end

`ifdef QDEC_INDEX_EN
    always_ff @(posedge clk) begin
        if (!reset_n) idx_q <= 1'b0;
        else          idx_q <= idx_rise;
    end
    assign index_pulse = idx_q;
`endif

    assign step     = step_q;
    assign dir      = dir_q;
    assign position = pos_q;
    assign error    = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder with default parameters; expected values are hand-derived.
module tb_quadrature_decoder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_in = 1'b0, b_in = 1'b0, clear = 1'b0, error_clr = 1'b0;
    logic        step, dir, error;
    logic [15:0] position;
`ifdef QDEC_INDEX_EN
    logic        z_in = 1'b0;
    logic        index_pulse;
`endif
    int checks = 0, failures = 0, nsteps = 0;

    quadrature_decoder dut (
        .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in),
`ifdef QDEC_INDEX_EN
        .z_in(z_in),
`endif
        .clear(clear), .error_clr(error_clr),
        .step(step), .dir(dir), .position(position), .error(error)
`ifdef QDEC_INDEX_EN
        , .index_pulse(index_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (step) nsteps++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ab(input logic [1:0] v, input int n);
        a_in = v[1];
        b_in = v[0];
        run(n);
    endtask

    logic [1:0] upseq[7] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] dnseq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    initial begin
        // Reset state
        run(3);
        check("rst_pos", position, 0);
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_err", error, 0);
        reset_n = 1'b1;
        run(10);
        check("prime_nostep", nsteps, 0);

        // Up count with latency: new level sampled at the next edge, step 7 edges later
        nsteps = 0;
        a_in = 1'b1;
        run(7);
        check("lat_early", step, 0);
        run(1);
        check("lat_step", step, 1);
        check("lat_pos", position, 1);
        check("lat_dir", dir, 1);
        run(1);
        check("step_1cyc", step, 0);
        run(1);
        for (int i = 0; i < 7; i++) ab(upseq[i], 10);
        check("up_steps", nsteps, 8);
        check("up_pos", position, 8);
        check("up_dir", dir, 1);

        // Clear, then count down through zero
        clear = 1'b1; run(1); clear = 1'b0;
        check("clr_pos", position, 0);
        nsteps = 0;
        for (int i = 0; i < 4; i++) ab(dnseq[i], 10);
        check("dn_steps", nsteps, 4);
        check("dn_pos", position, 16'hFFFC);
        check("dn_dir", dir, 0);

        // Glitch rejection: 3-cycle pulse dropped, 4-cycle pulse accepted
        nsteps = 0;
        a_in = 1'b1; run(3); a_in = 1'b0; run(15);
        check("glitch3_steps", nsteps, 0);
        check("glitch3_pos", position, 16'hFFFC);
        a_in = 1'b1; run(4); a_in = 1'b0; run(6);
        check("glitch4_steps", nsteps, 1);
        check("glitch4_pos", position, 16'hFFFD);
        check("glitch4_dir", dir, 1);
        run(10);
        check("restore_steps", nsteps, 2);
        check("restore_pos", position, 16'hFFFC);
        check("restore_dir", dir, 0);

        // Illegal jump 00 -> 11
        nsteps = 0;
        ab(2'b11, 12);
        check("ill_err", error, 1);
        check("ill_steps", nsteps, 0);
        check("ill_pos", position, 16'hFFFC);
        error_clr = 1'b1; run(1); error_clr = 1'b0;
        check("errclr", error, 0);
        // 11 -> 00 with error_clr landing on the same edge as the error
        ab(2'b00, 7);
        check("ill2_pre", error, 0);
        error_clr = 1'b1; run(1); error_clr = 1'b0;
        check("err_over_clr", error, 1);
        run(4);
        check("ill2_pos", position, 16'hFFFC);
        check("ill2_steps", nsteps, 0);
        error_clr = 1'b1; run(1); error_clr = 1'b0;
        check("errclr2", error, 0);

        // Clear coincident with a step
        a_in = 1'b1;
        run(7);
        clear = 1'b1; run(1); clear = 1'b0;
        check("clrstep_step", step, 1);
        check("clrstep_pos", position, 0);
        check("clrstep_dir", dir, 1);
        run(2);

        // Reset mid-motion with A/B = 11
        ab(2'b11, 10);
        check("pre_rst_pos", position, 1);
        reset_n = 1'b0; run(2);
        check("midrst_pos", position, 0);
        reset_n = 1'b1;
        nsteps = 0;
        run(15);
        check("reprime_steps", nsteps, 0);
        check("reprime_pos", position, 0);
        check("reprime_err", error, 0);
        ab(2'b01, 10);
        check("post_rst_pos", position, 1);
        check("post_rst_steps", nsteps, 1);

`ifdef QDEC_INDEX_EN
        ab(2'b00, 10); ab(2'b10, 10); ab(2'b11, 10); ab(2'b01, 10);
        check("idx_pre_pos", position, 5);
        z_in = 1'b1;
        run(7);
        check("idx_early", index_pulse, 0);
        run(1);
        check("idx_pulse", index_pulse, 1);
        check("idx_pos", position, 0);
        run(1);
        check("idx_1cyc", index_pulse, 0);
        z_in = 1'b0;
        ab(2'b00, 10);
        check("idx_next_pos", position, 1);
        check("idx_fall_nopulse", index_pulse, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
